coin_accumulator: RTL and testbench
===================================

// Module: coin_accumulator
// PURPOSE
//  Front-end stage of the vending machine. Accepts coin-insert events and accumulates
//  the credit in 5-cent units. When credit reaches PRICE, it holds the total stable on
//  o_sum for the change-subtractor stage, which computes change = o_sum - PRICE.
//  Also handles cancel/refund, and rejects coins while a vend or refund is in progress.
// PARAMETERS
//  SUM_W  4  width of credit register, in 5-cent units
//  PRICE  4  product price in 5-cent units (4 = 20 cents)
// PORTS
//  i_clk          in   1      clock, all logic on rising edge
//  i_rst          in   1      synchronous reset, active-high
//  i_coin_valid   in   1      one-cycle coin event strobe
//  i_coin         in   2      coin code: 01=5c(1u) 10=10c(2u) 11=25c(5u) 00=invalid
//  i_cancel       in   1      one-cycle cancel request
//  i_ack          in   1      downstream has consumed o_sum (change dispensed)
//  o_sum          out  SUM_W  accumulated credit in units, registered
//  o_vend         out  1      credit >= PRICE; o_sum is valid for subtraction
//  o_refund       out  1      one-cycle pulse; return o_sum in full
//  o_coin_reject  out  1      one-cycle pulse; coin was not accepted (returned)
// BEHAVIOUR
//  Reset: state IDLE. o_sum=0, o_vend=0, o_refund=0, o_coin_reject=0. Reset overrides everything.
//  FSM states: IDLE (sum=0), COLLECT (0<sum<PRICE), VEND, REFUND. All outputs registered.
//  IDLE/COLLECT with accepted coin at edge N:
//   - sum_next = sum + value, visible on o_sum after edge N.
//   - If sum_next >= PRICE: go to VEND, and o_vend=1 in the same cycle o_sum updates.
//   - Otherwise go to COLLECT.
//  Coin code 00 with i_coin_valid=1: not accepted. o_coin_reject pulses 1 cycle; sum unchanged.
//  Max sum: at most (PRICE-1) + 5 = 8 with defaults, so no overflow of SUM_W.
//   - An add that would exceed 2**SUM_W-1 is rejected instead.
//  VEND: o_vend=1 and o_sum held constant until i_ack=1.
//   - On the i_ack edge: go to IDLE; next cycle o_sum=0, o_vend=0.
//   - Coins in VEND are rejected with a reject pulse. i_cancel in VEND is ignored.
//  Cancel in COLLECT: go to REFUND. o_refund=1 for exactly 1 cycle with o_sum = credit.
//   - Then IDLE, with o_sum=0 on the following cycle.
//   - Coins during REFUND are rejected.
//  Cancel in IDLE: ignored, no pulse.
//  Coin + cancel in the same cycle (IDLE/COLLECT): cancel wins.
//   - Coin rejected (o_coin_reject=1), then refund of the prior credit if it is nonzero.
//  i_ack outside VEND: ignored.
//  o_vend and o_refund are never both 1.
//  Reset asserted mid-VEND or mid-REFUND: outputs cleared next cycle; no refund pulse is issued.
// TESTING
//  T1: 4x nickel (01) on separate cycles -> o_sum 1,2,3,4; o_vend=1 with o_sum=4.
//      Then i_ack -> o_sum=0, o_vend=0.
//  T2: dime then quarter -> o_sum=2, then o_sum=7 with o_vend=1.
//      Downstream change = 3; o_sum holds 7 across 5 idle cycles until i_ack.
//  T3: dime, nickel, cancel -> o_refund=1 for one cycle with o_sum=3, then o_sum=0.
//      No o_vend at any point.
//  T4: in VEND (o_sum=5), insert dime -> o_coin_reject pulse; o_sum stays 5.
//      Also assert i_cancel in VEND -> no effect.
//  T5: i_coin=00 with valid in IDLE -> reject pulse, o_sum=0.
//      Coin + cancel same cycle with credit 2 -> reject pulse plus refund of 2.
//  T6: i_rst=1 during VEND with o_sum=6 -> next cycle all outputs 0, state IDLE.
//      Nickel afterwards -> o_sum=1.

Source files
------------

// File: rtl/coin_accumulator.sv
// Vending machine front end: accumulates coin credit in 5-cent units,
// holds the total for the change stage on vend, and handles cancel/refund.
module coin_accumulator #(
    parameter int unsigned SUM_W = 4,
    parameter int unsigned PRICE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_coin_valid,
    input  logic [1:0]       i_coin,
    input  logic             i_cancel,
    input  logic             i_ack,
    output logic [SUM_W-1:0] o_sum,
    output logic             o_vend,
    output logic             o_refund,
    output logic             o_coin_reject
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        REFUND
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next;
    logic             vend;
    logic             vend_next;
    logic             refund;
    logic             refund_next;
    logic             reject;
    logic             reject_next;
    logic [SUM_W:0]   value;
    logic [SUM_W:0]   total;
    logic             fits;

    // Coin value in units; an extra carry bit catches credit overflow.
    always_comb begin
        value = '0;
        case (i_coin)
            2'b01:   value = (SUM_W+1)'(1);
            2'b10:   value = (SUM_W+1)'(2);
            2'b11:   value = (SUM_W+1)'(5);
            default: value = '0;
        endcase
        total = {1'b0, sum} + value;
        fits  = (value != '0) && !total[SUM_W];
    end

    // Next state and next registered outputs.
    always_comb begin
        state_next  = state;
        sum_next    = sum;
        vend_next   = vend;
        refund_next = 1'b0;
        reject_next = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (i_cancel) begin
                    // Cancel wins over a simultaneous coin.
                    reject_next = i_coin_valid;
                    if (sum != '0) begin
                        state_next  = REFUND;
                        refund_next = 1'b1;
                    end
                end else if (i_coin_valid) begin
                    if (!fits) begin
                        reject_next = 1'b1;
                    end else begin
                        sum_next = total[SUM_W-1:0];
                        if (total >= (SUM_W+1)'(PRICE)) begin
                            state_next = VEND;
                            vend_next  = 1'b1;
                        end else begin
                            state_next = COLLECT;
                        end
                    end
                end
            end
            VEND: begin
                reject_next = i_coin_valid;
                if (i_ack) begin
                    state_next = IDLE;
                    sum_next   = '0;
                    vend_next  = 1'b0;
                end
            end
            REFUND: begin
                reject_next = i_coin_valid;
                state_next  = IDLE;
                sum_next    = '0;
            end
            default: begin
                state_next = IDLE;
                sum_next   = '0;
                vend_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            sum    <= '0;
            vend   <= 1'b0;
            refund <= 1'b0;
            reject <= 1'b0;
        end else begin
            state  <= state_next;
            sum    <= sum_next;
            vend   <= vend_next;
            refund <= refund_next;
            reject <= reject_next;
        end
    end

    assign o_sum         = sum;
    assign o_vend        = vend;
    assign o_refund      = refund;
    assign o_coin_reject = reject;

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: directed scenarios then random traffic,
// checked each cycle against a credit-level reference model.
module tb_coin_accumulator;

    localparam int SUM_W = 4;
    localparam int PRICE = 4;
    localparam int MAXC  = (1 << SUM_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_coin_valid = 1'b0;
    logic [1:0]       i_coin = 2'b00;
    logic             i_cancel = 1'b0;
    logic             i_ack = 1'b0;
    logic [SUM_W-1:0] o_sum;
    logic             o_vend;
    logic             o_refund;
    logic             o_coin_reject;

    int tests = 0;
    int failed = 0;

    int credit = 0;
    bit vending = 0;
    bit refunding = 0;
    bit exp_rej = 0;

    coin_accumulator #(.SUM_W(SUM_W), .PRICE(PRICE)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_coin_valid(i_coin_valid),
        .i_coin(i_coin),
        .i_cancel(i_cancel),
        .i_ack(i_ack),
        .o_sum(o_sum),
        .o_vend(o_vend),
        .o_refund(o_refund),
        .o_coin_reject(o_coin_reject)
    );

    always #5 i_clk = ~i_clk;

    function automatic int coin_units(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    // Reference: a credit amount plus "waiting for ack" / "returning money".
    task automatic model(input bit v, input logic [1:0] c,
                         input bit cn, input bit ak, input bit r);
        int u;
        exp_rej = 1'b0;
        if (r) begin
            credit = 0;
            vending = 0;
            refunding = 0;
        end else if (refunding) begin
            refunding = 0;
            credit = 0;
            exp_rej = v;
        end else if (vending) begin
            exp_rej = v;
            if (ak) begin
                vending = 0;
                credit = 0;
            end
        end else if (cn) begin
            exp_rej = v;
            if (credit > 0) refunding = 1;
        end else if (v) begin
            u = coin_units(c);
            if (u == 0 || credit + u > MAXC) begin
                exp_rej = 1'b1;
            end else begin
                credit += u;
                if (credit >= PRICE) vending = 1;
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input bit v, input logic [1:0] c, input bit cn,
                        input bit ak, input bit r, input string tag);
        i_coin_valid = v;
        i_coin = c;
        i_cancel = cn;
        i_ack = ak;
        i_rst = r;
        @(posedge i_clk);
        #1;
        model(v, c, cn, ak, r);
        check({tag, "_sum"}, int'(o_sum), credit);
        check({tag, "_vend"}, int'(o_vend), int'(vending));
        check({tag, "_refund"}, int'(o_refund), int'(refunding));
        check({tag, "_reject"}, int'(o_coin_reject), int'(exp_rej));
        check({tag, "_excl"}, int'(o_vend & o_refund), 0);
    endtask

    task automatic idle(input string tag);
        step(0, 2'b00, 0, 0, 0, tag);
    endtask

    initial begin
        bit v, cn, ak, r;
        logic [1:0] c;

        step(0, 2'b00, 0, 0, 1, "reset");
        check("reset_sum0", int'(o_sum), 0);
        idle("reset_idle");

        // T1: four nickels
        step(1, 2'b01, 0, 0, 0, "t1_n1");
        check("t1_sum1", int'(o_sum), 1);
        step(1, 2'b01, 0, 0, 0, "t1_n2");
        step(1, 2'b01, 0, 0, 0, "t1_n3");
        step(1, 2'b01, 0, 0, 0, "t1_n4");
        check("t1_sum4", int'(o_sum), 4);
        check("t1_vend", int'(o_vend), 1);
        step(0, 2'b00, 0, 1, 0, "t1_ack");
        check("t1_cleared", int'(o_sum), 0);

        // T2: dime, quarter, hold across idle cycles, ack
        step(1, 2'b10, 0, 0, 0, "t2_dime");
        step(1, 2'b11, 0, 0, 0, "t2_quarter");
        check("t2_sum7", int'(o_sum), 7);
        check("t2_change", int'(o_sum) - PRICE, 3);
        for (int i = 0; i < 5; i++) idle("t2_hold");
        check("t2_held7", int'(o_sum), 7);
        step(0, 2'b00, 0, 1, 0, "t2_ack");

        // T3: dime, nickel, cancel
        step(1, 2'b10, 0, 0, 0, "t3_dime");
        step(1, 2'b01, 0, 0, 0, "t3_nickel");
        step(0, 2'b00, 1, 0, 0, "t3_cancel");
        check("t3_refund", int'(o_refund), 1);
        check("t3_refund_sum", int'(o_sum), 3);
        idle("t3_after");
        check("t3_sum0", int'(o_sum), 0);
        check("t3_no_vend", int'(o_vend), 0);

        // T4: vend at 5, then coin and cancel are ignored
        step(1, 2'b11, 0, 0, 0, "t4_quarter");
        step(1, 2'b10, 0, 0, 0, "t4_dime_in_vend");
        check("t4_reject", int'(o_coin_reject), 1);
        check("t4_sum5", int'(o_sum), 5);
        step(0, 2'b00, 1, 0, 0, "t4_cancel_in_vend");
        check("t4_still_vend", int'(o_vend), 1);
        step(0, 2'b00, 0, 1, 0, "t4_ack");

        // T5: invalid coin, then coin+cancel with credit 2
        step(1, 2'b00, 0, 0, 0, "t5_bad_coin");
        check("t5_reject", int'(o_coin_reject), 1);
        step(1, 2'b10, 0, 0, 0, "t5_dime");
        step(1, 2'b01, 1, 0, 0, "t5_coin_cancel");
        check("t5_both_rej", int'(o_coin_reject), 1);
        check("t5_both_ref", int'(o_refund), 1);
        check("t5_ref_sum2", int'(o_sum), 2);
        idle("t5_after");
        step(0, 2'b00, 1, 0, 0, "t5_cancel_idle");
        step(0, 2'b00, 0, 1, 0, "t5_ack_idle");

        // T6: reset during vend at 6
        step(1, 2'b01, 0, 0, 0, "t6_nickel");
        step(1, 2'b11, 0, 0, 0, "t6_quarter");
        check("t6_sum6", int'(o_sum), 6);
        step(0, 2'b00, 0, 0, 1, "t6_reset");
        check("t6_vend0", int'(o_vend), 0);
        step(1, 2'b01, 0, 0, 0, "t6_nickel_after");
        check("t6_sum1", int'(o_sum), 1);

        // Reset during refund issues no further refund
        step(0, 2'b00, 1, 0, 0, "rr_cancel");
        step(0, 2'b00, 0, 0, 1, "rr_reset");
        check("rr_refund0", int'(o_refund), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 1) == 1);
            c  = 2'($urandom_range(0, 3));
            cn = ($urandom_range(0, 7) == 0);
            ak = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 49) == 0);
            step(v, c, cn, ak, r, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
